// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator scheduler: sizing defaults,
// FSM state encoding and travel-direction encoding.
package elevator_pkg;

    localparam int unsigned N_FLOORS   = 8;
    localparam int unsigned DOOR_TICKS = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_MOVE_UP   = 2'd1;
    localparam state_t ST_MOVE_DOWN = 2'd2;
    localparam state_t ST_DOOR      = 2'd3;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/elevator_req_bank.sv
// Latched hall-up, hall-down and in-car request registers.
// A bit sets the cycle after its input is high; clr forces bits low
// and takes priority over a set of the same bit in the same cycle.
module elevator_req_bank
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS = elevator_pkg::N_FLOORS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] set_up,
    input  logic [N_FLOORS-1:0] set_down,
    input  logic [N_FLOORS-1:0] set_car,
    input  logic [N_FLOORS-1:0] clr,
    output logic [N_FLOORS-1:0] up_req,
    output logic [N_FLOORS-1:0] down_req,
    output logic [N_FLOORS-1:0] car_req
);

    // Accumulate requests, dropping any bit the scheduler is servicing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_req   <= '0;
            down_req <= '0;
            car_req  <= '0;
        end else begin
            up_req   <= (up_req   | set_up)   & ~clr;
            down_req <= (down_req | set_down) & ~clr;
            car_req  <= (car_req  | set_car)  & ~clr;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler: direction-preferring FSM, floor counter
// and door timer, with request latching delegated to elevator_req_bank.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS   = elevator_pkg::N_FLOORS,
    parameter int unsigned DOOR_TICKS = elevator_pkg::DOOR_TICKS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic [N_FLOORS-1:0]         up,
    input  logic [N_FLOORS-1:0]         down,
    input  logic [N_FLOORS-1:0]         elevator_btn,
    output logic [$clog2(N_FLOORS)-1:0] floor,
    output logic                        moving_up,
    output logic                        moving_down,
    output logic                        door_open,
    output logic [N_FLOORS-1:0]         pending
);

    localparam int unsigned FW = $clog2(N_FLOORS);
    localparam int unsigned CW = $clog2(DOOR_TICKS + 1);

    state_t                state, state_nx;
    logic                  dir, dir_nx;
    logic [FW-1:0]         floor_nx, door_floor, step_up, step_dn;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  enter_door, call_here;
    logic [N_FLOORS-1:0]   up_req, down_req, car_req, clr;

    function automatic logic [N_FLOORS-1:0] above_mask(input logic [FW-1:0] f);
        above_mask = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++)
            if (FW'(i) > f) above_mask[i] = 1'b1;
    endfunction

    function automatic logic [N_FLOORS-1:0] below_mask(input logic [FW-1:0] f);
        below_mask = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++)
            if (FW'(i) < f) below_mask[i] = 1'b1;
    endfunction

    elevator_req_bank #(.N_FLOORS(N_FLOORS)) u_req_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_up   (up),
        .set_down (down),
        .set_car  (elevator_btn),
        .clr      (clr),
        .up_req   (up_req),
        .down_req (down_req),
        .car_req  (car_req)
    );

    assign pending     = up_req | down_req | car_req;
    assign moving_up   = (state == ST_MOVE_UP);
    assign moving_down = (state == ST_MOVE_DOWN);
    assign door_open   = (state == ST_DOOR);
    assign step_up     = floor + FW'(1);
    assign step_dn     = floor - FW'(1);
    assign call_here   = up[floor] | down[floor] | elevator_btn[floor];

    // Next-state, floor, direction and door-timer decisions; also selects
    // which floor's requests are being serviced so the bank can clear them.
    always_comb begin
        state_nx   = state;
        dir_nx     = dir;
        floor_nx   = floor;
        cnt_nx     = cnt;
        door_floor = floor;
        enter_door = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending[floor]) begin
                    state_nx   = ST_DOOR;
                    enter_door = 1'b1;
                end else if (dir == DIR_UP && |(pending & above_mask(floor))) begin
                    state_nx = ST_MOVE_UP;
                end else if (dir == DIR_DOWN && |(pending & below_mask(floor))) begin
                    state_nx = ST_MOVE_DOWN;
                end else if (|(pending & above_mask(floor))) begin
                    state_nx = ST_MOVE_UP;
                    dir_nx   = DIR_UP;
                end else if (|(pending & below_mask(floor))) begin
                    state_nx = ST_MOVE_DOWN;
                    dir_nx   = DIR_DOWN;
                end
            end
            ST_MOVE_UP: begin
                if (floor == FW'(N_FLOORS - 1)) begin
                    state_nx   = ST_DOOR;
                    enter_door = 1'b1;
                end else if (tick) begin
                    floor_nx = step_up;
                    if (car_req[step_up] || up_req[step_up] ||
                        !(|(pending & above_mask(step_up)))) begin
                        state_nx   = ST_DOOR;
                        enter_door = 1'b1;
                        door_floor = step_up;
                    end
                end
            end
            ST_MOVE_DOWN: begin
                if (floor == '0) begin
                    state_nx   = ST_DOOR;
                    enter_door = 1'b1;
                end else if (tick) begin
                    floor_nx = step_dn;
                    if (car_req[step_dn] || down_req[step_dn] ||
                        !(|(pending & below_mask(step_dn)))) begin
                        state_nx   = ST_DOOR;
                        enter_door = 1'b1;
                        door_floor = step_dn;
                    end
                end
            end
            default: begin
                // Door closes on the tick that brings the count to zero.
                if (call_here) begin
                    cnt_nx = CW'(DOOR_TICKS);
                end else if (tick) begin
                    if (cnt <= CW'(1)) begin
                        cnt_nx   = '0;
                        state_nx = ST_IDLE;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
            end
        endcase
        if (enter_door) cnt_nx = CW'(DOOR_TICKS);
        clr = '0;
        if (enter_door || state == ST_DOOR) clr[door_floor] = 1'b1;
    end

    // Scheduler state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dir   <= DIR_UP;
            floor <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            dir   <= dir_nx;
            floor <= floor_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed self-checking bench for elevator_scheduler.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [7:0] up, down, elevator_btn;
    logic [2:0] floor;
    logic       moving_up, moving_down, door_open;
    logic [7:0] pending;

    int errors = 0;
    int checks = 0;

    elevator_scheduler #(.N_FLOORS(8), .DOOR_TICKS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .up           (up),
        .down         (down),
        .elevator_btn (elevator_btn),
        .floor        (floor),
        .moving_up    (moving_up),
        .moving_down  (moving_down),
        .door_open    (door_open),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // status = {moving_up, moving_down, door_open}
    task automatic chk_st(input string tag, input logic [2:0] exp);
        check(tag, 8'({moving_up, moving_down, door_open}), 8'(exp));
    endtask

    task automatic chk_fl(input string tag, input logic [2:0] exp);
        check(tag, 8'(floor), 8'(exp));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        cyc(n);
        tick = 1'b0;
    endtask

    task automatic press(input logic [7:0] u, input logic [7:0] d, input logic [7:0] b);
        up = u;
        down = d;
        elevator_btn = b;
        cyc(1);
        up = '0;
        down = '0;
        elevator_btn = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        tick = 1'b0;
        up = '0;
        down = '0;
        elevator_btn = '0;
        cyc(2);
        chk_fl("rst floor", 3'd0);
        check("rst pending", pending, 8'h00);
        chk_st("rst status", 3'b000);
        rst_n = 1'b1;
        cyc(1);

        // Car call to floor 5
        press(8'h00, 8'h00, 8'h20);
        check("c5 pending", pending, 8'h20);
        chk_st("c5 still idle", 3'b000);
        cyc(1);
        chk_st("c5 moving up", 3'b100);
        ticks(4);
        chk_fl("c5 floor4", 3'd4);
        chk_st("c5 passing 4", 3'b100);
        ticks(1);
        chk_fl("c5 floor5", 3'd5);
        chk_st("c5 door", 3'b001);
        check("c5 cleared", pending, 8'h00);
        ticks(3);
        chk_st("c5 door 3 ticks", 3'b001);
        ticks(1);
        chk_st("c5 closed", 3'b000);
        chk_fl("c5 stays", 3'd5);

        // Hall call at the current floor opens the door in place
        do_reset();
        press(8'h01, 8'h00, 8'h00);
        check("h0 pending", pending, 8'h01);
        cyc(1);
        chk_st("h0 door", 3'b001);
        chk_fl("h0 floor", 3'd0);
        check("h0 cleared", pending, 8'h00);
        ticks(3);
        chk_st("h0 open 3", 3'b001);
        ticks(1);
        chk_st("h0 closed", 3'b000);
        cyc(2);
        chk_st("h0 no travel", 3'b000);
        chk_fl("h0 floor kept", 3'd0);

        // Re-press at an open door reloads the timer and does not latch
        do_reset();
        press(8'h00, 8'h00, 8'h04);
        cyc(1);
        ticks(2);
        chk_fl("rl floor2", 3'd2);
        chk_st("rl door", 3'b001);
        ticks(3);
        chk_st("rl open 3", 3'b001);
        press(8'h04, 8'h00, 8'h00);
        check("rl no latch", pending, 8'h00);
        chk_st("rl reloaded", 3'b001);
        ticks(3);
        chk_st("rl open +3", 3'b001);
        ticks(1);
        chk_st("rl closed", 3'b000);
        check("rl pending", pending, 8'h00);

        // Pass a down-call going up, stop at car call, reverse
        do_reset();
        press(8'h00, 8'h00, 8'h40);
        cyc(1);
        ticks(1);
        chk_fl("rv floor1", 3'd1);
        press(8'h00, 8'h08, 8'h00);
        check("rv pending", pending, 8'h48);
        ticks(2);
        chk_fl("rv floor3", 3'd3);
        chk_st("rv passes 3", 3'b100);
        ticks(3);
        chk_fl("rv floor6", 3'd6);
        chk_st("rv door6", 3'b001);
        check("rv pend6", pending, 8'h08);
        ticks(4);
        chk_st("rv idle6", 3'b000);
        cyc(1);
        chk_st("rv moving down", 3'b010);
        ticks(3);
        chk_fl("rv floor3b", 3'd3);
        chk_st("rv door3", 3'b001);
        check("rv pend3", pending, 8'h00);
        ticks(4);

        // Position at floor 4 with direction down
        press(8'h00, 8'h00, 8'h40);
        cyc(1);
        chk_st("pos up", 3'b100);
        ticks(3);
        ticks(4);
        press(8'h00, 8'h00, 8'h10);
        cyc(1);
        chk_st("pos down", 3'b010);
        ticks(2);
        chk_fl("pos floor4", 3'd4);
        ticks(4);
        chk_st("pos idle", 3'b000);

        // Direction preference: down to 0 first, then up to 7
        press(8'h80, 8'h01, 8'h00);
        check("dp pending", pending, 8'h81);
        cyc(1);
        chk_st("dp down first", 3'b010);
        ticks(4);
        chk_fl("dp floor0", 3'd0);
        chk_st("dp door0", 3'b001);
        check("dp pend0", pending, 8'h80);
        ticks(4);
        cyc(1);
        chk_st("dp up", 3'b100);
        ticks(6);
        chk_fl("dp floor6", 3'd6);
        chk_st("dp passing 6", 3'b100);
        ticks(1);
        chk_fl("dp floor7", 3'd7);
        chk_st("dp door7", 3'b001);
        check("dp pend7", pending, 8'h00);

        // Asynchronous reset mid-travel
        do_reset();
        press(8'h00, 8'h00, 8'h80);
        cyc(1);
        ticks(3);
        chk_fl("ar floor3", 3'd3);
        check("ar pending", pending, 8'h80);
        rst_n = 1'b0;
        #2;
        chk_fl("ar floor0", 3'd0);
        check("ar pend0", pending, 8'h00);
        chk_st("ar status", 3'b000);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk_st("ar idle", 3'b000);
        press(8'h00, 8'h00, 8'h02);
        cyc(1);
        chk_st("ar up again", 3'b100);
        ticks(1);
        chk_fl("ar floor1", 3'd1);
        chk_st("ar door1", 3'b001);
        check("ar pend1", pending, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
